// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback scheduler.
package regfile_pkg;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 2 ** REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-request round-robin arbiter; bit 0 is the ALU, bit 1 the LSU.
module wb_rr_arbiter
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   wb_src_e last;

   // Reset to LSU so the ALU wins the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= WB_LSU;
      end else if (|gnt) begin
         last <= gnt[1] ? WB_LSU : WB_ALU;
      end
   end

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == WB_LSU) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the register-file write port between ALU and LSU writeback and
// tracks pending destinations to stall dependent issue.
module regfile_wb_sched #(
   parameter int unsigned XLEN   = regfile_pkg::XLEN,
   parameter int unsigned REG_AW = regfile_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic [REG_AW-1:0] issue_rs1,
   input  logic [REG_AW-1:0] issue_rs2,
   output logic              issue_stall,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              lsu_ready,
   output logic              rf_wr_en,
   output logic [REG_AW-1:0] rf_wr_addr,
   output logic [XLEN-1:0]   rf_wr_data
);

   localparam int unsigned NREGS = 2 ** REG_AW;

   logic [NREGS-1:0]  pending;
   logic [NREGS-1:0]  pending_nxt;
   logic [1:0]        gnt;
   logic              issue_accept;
   logic [REG_AW-1:0] sel_rd;
   logic [XLEN-1:0]   sel_data;
   logic              wr_en_nxt;

   wb_rr_arbiter u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({lsu_valid, alu_valid}),
      .gnt   (gnt)
   );

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];

   assign issue_stall  = issue_valid &&
                         (pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd]);
   assign issue_accept = issue_valid && !issue_stall;

   // Clear on port write first so a same-edge set of the same register wins
   always_comb begin
      pending_nxt = pending;
      if (rf_wr_en) begin
         pending_nxt[rf_wr_addr] = 1'b0;
      end
      if (issue_accept && (issue_rd != '0)) begin
         pending_nxt[issue_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_comb begin
      sel_rd    = gnt[1] ? lsu_rd   : alu_rd;
      sel_data  = gnt[1] ? lsu_data : alu_data;
      wr_en_nxt = (|gnt) && (sel_rd != '0);
   end

   // Address and data hold when nothing is written
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending    <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         pending  <= pending_nxt;
         rf_wr_en <= wr_en_nxt;
         if (wr_en_nxt) begin
            rf_wr_addr <= sel_rd;
            rf_wr_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a write-port scoreboard.
module tb_regfile_wb_sched;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_stall;
   logic        alu_valid, lsu_valid;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   regfile_wb_sched #(.XLEN(32), .REG_AW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_stall (issue_stall),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .lsu_ready   (lsu_ready),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data)
   );

   always #5 clk = ~clk;

   task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every port write must match the next expected entry
   always @(negedge clk) begin
      if (rf_wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=addr %0d data %0h required=no write",
                     rf_wr_addr, rf_wr_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            do_check("sb_addr", 32'(rf_wr_addr), 32'(e.addr));
            do_check("sb_data", rf_wr_data, e.data);
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      issue_valid = 1'b1;
      issue_rd    = 5'd1;
      issue_rs1   = 5'd3;
      issue_rs2   = 5'd4;
      alu_valid   = 1'b1;
      alu_rd      = 5'd1;
      alu_data    = 32'h1;
      lsu_valid   = 1'b1;
      lsu_rd      = 5'd2;
      lsu_data    = 32'h2;

      // Reset held two edges with both sources requesting
      tick();
      tick();
      do_check("rst_wr_en", 32'(rf_wr_en), 32'd0);
      do_check("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
      do_check("rst_stall_a", 32'(issue_stall), 32'd0);
      issue_rs1 = 5'd31;
      issue_rs2 = 5'd17;
      issue_rd  = 5'd9;
      #1;
      do_check("rst_stall_b", 32'(issue_stall), 32'd0);
      do_check("rst_alu_ready", 32'(alu_ready), 32'd1);

      // Contention: strict alternation starting with ALU
      rst_n       = 1'b1;
      issue_valid = 1'b0;
      alu_rd      = 5'd3;
      alu_data    = 32'hA;
      lsu_rd      = 5'd4;
      lsu_data    = 32'hB;
      for (int i = 0; i < 4; i++) begin
         #1;
         do_check("cont_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         do_check("cont_lsu_ready", 32'(lsu_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
         if (i % 2 == 0) push(5'd3, 32'hA);
         else            push(5'd4, 32'hB);
         tick();
      end

      // x0 suppression
      lsu_valid = 1'b0;
      alu_rd    = 5'd0;
      alu_data  = 32'hFFFF_FFFF;
      #1;
      do_check("x0_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid   = 1'b0;
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      issue_rs1   = 5'd0;
      issue_rs2   = 5'd0;
      #1;
      do_check("x0_wr_en", 32'(rf_wr_en), 32'd0);
      do_check("x0_addr_hold", 32'(rf_wr_addr), 32'd4);
      do_check("x0_data_hold", rf_wr_data, 32'hB);
      do_check("raw_c0_stall", 32'(issue_stall), 32'd0);
      tick();

      // RAW: dependent issue stalls until the LSU write clears pending[5]
      issue_rd  = 5'd6;
      issue_rs1 = 5'd5;
      lsu_valid = 1'b1;
      lsu_rd    = 5'd5;
      lsu_data  = 32'h55;
      #1;
      do_check("raw_c1_stall", 32'(issue_stall), 32'd1);
      do_check("raw_c1_lsu_ready", 32'(lsu_ready), 32'd1);
      push(5'd5, 32'h55);
      tick();
      lsu_valid = 1'b0;
      #1;
      do_check("raw_c2_stall", 32'(issue_stall), 32'd1);
      do_check("raw_c2_wr_en", 32'(rf_wr_en), 32'd1);
      do_check("raw_c2_addr", 32'(rf_wr_addr), 32'd5);
      tick();
      #1;
      do_check("raw_c3_stall", 32'(issue_stall), 32'd0);
      tick();
      issue_valid = 1'b0;

      // Set/clear collision on register 7
      alu_valid = 1'b1;
      alu_rd    = 5'd7;
      alu_data  = 32'h77;
      #1;
      do_check("col_alu_ready", 32'(alu_ready), 32'd1);
      push(5'd7, 32'h77);
      tick();
      alu_valid   = 1'b0;
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      issue_rs1   = 5'd0;
      issue_rs2   = 5'd0;
      #1;
      do_check("col_wr_en", 32'(rf_wr_en), 32'd1);
      do_check("col_issue_stall", 32'(issue_stall), 32'd0);
      tick();
      issue_rd  = 5'd8;
      issue_rs1 = 5'd7;
      #1;
      do_check("col_dep_stall", 32'(issue_stall), 32'd1);
      issue_valid = 1'b0;
      tick();

      // Mid-operation reset with pending[9] set and a write granted
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      issue_rs1   = 5'd0;
      #1;
      do_check("mid_issue9_stall", 32'(issue_stall), 32'd0);
      tick();
      issue_rd  = 5'd0;
      issue_rs1 = 5'd9;
      #1;
      do_check("mid_pending9_stall", 32'(issue_stall), 32'd1);
      issue_valid = 1'b0;
      alu_valid   = 1'b1;
      alu_rd      = 5'd10;
      alu_data    = 32'hAA;
      rst_n       = 1'b0;
      #1;
      do_check("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      rst_n       = 1'b1;
      alu_valid   = 1'b0;
      issue_valid = 1'b1;
      issue_rs1   = 5'd9;
      issue_rs2   = 5'd7;
      issue_rd    = 5'd6;
      #1;
      do_check("mid_stall_cleared", 32'(issue_stall), 32'd0);
      do_check("mid_wr_en", 32'(rf_wr_en), 32'd0);
      issue_valid = 1'b0;
      tick();

      // First tie after reset goes to ALU again
      alu_valid = 1'b1;
      alu_rd    = 5'd11;
      alu_data  = 32'h1111;
      lsu_valid = 1'b1;
      lsu_rd    = 5'd12;
      lsu_data  = 32'h2222;
      #1;
      do_check("tie2_alu_ready", 32'(alu_ready), 32'd1);
      do_check("tie2_lsu_ready", 32'(lsu_ready), 32'd0);
      push(5'd11, 32'h1111);
      tick();
      alu_valid = 1'b0;
      #1;
      do_check("tie2b_lsu_ready", 32'(lsu_ready), 32'd1);
      push(5'd12, 32'h2222);
      tick();
      lsu_valid = 1'b0;
      tick();
      tick();
      do_check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Writeback scheduler and scoreboard for the 32×32 register file. It shares the file's single write port between the ALU and LSU writeback sources using round-robin arbitration, registers the granted write onto the port, and tracks pending destination registers. From that tracking it raises a RAW/WAW stall toward the issue stage. It sits between the execute/memory units and `registers`, and drives `wr_en`, `rd_addr` and `rd_data` directly.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `REG_AW`, 5, register address width (2^REG_AW registers).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `issue_valid`  in  1  issue stage presents an instruction that writes `issue_rd`.
- `issue_rd`  in  REG_AW  destination register of the issuing instruction.
- `issue_rs1`, `issue_rs2`  in  REG_AW  source registers of the issuing instruction.
- `issue_stall`  out  1  issue must hold; the instruction is not accepted.
- `alu_valid`  in  1  ALU writeback request.
- `alu_rd`  in  REG_AW  ALU writeback destination.
- `alu_data`  in  XLEN  ALU writeback data.
- `alu_ready`  out  1  ALU request granted this cycle.
- `lsu_valid`, `lsu_rd`, `lsu_data`, `lsu_ready`: same as the four ALU ports, for the LSU.
- `rf_wr_en`  out  1  register-file write enable (registered).
- `rf_wr_addr`  out  REG_AW  register-file write address (registered).
- `rf_wr_data`  out  XLEN  register-file write data (registered).

## Operation
Scoreboard:
- `pending[2^REG_AW-1:0]`: one bit per register; bit 0 is hard-wired to 0.
- Issue accept: `issue_valid && !issue_stall`. On accept with `issue_rd != 0`, set `pending[issue_rd]`.
- `issue_stall = issue_valid && (pending[issue_rs1] | pending[issue_rs2] | pending[issue_rd])`. This is combinational from the registered `pending` vector.
- Clear `pending[rf_wr_addr]` on every edge where `rf_wr_en` = 1.
- If a set and a clear hit the same register on the same edge, the set wins.

Arbitration:
- Round-robin pointer `last` records the last granted source; 0 = ALU, 1 = LSU.
- Only one request valid: grant it.
- Both requests valid: grant the source other than `last`.
- `last` updates only on a grant.
- `alu_ready` / `lsu_ready` are combinational grants. Valid/ready handshake: a source holds `rd` and `data` stable until ready.
- At most one grant per cycle, so the port is never double-written.

Write port:
- Granted request with `rd != 0`: next cycle `rf_wr_en`=1, with `rd` and `data` registered.
- Granted request with `rd == 0`: handshake completes but `rf_wr_en` stays 0 (x0 suppression).
- No grant: `rf_wr_en`=0 next cycle. Address and data hold their previous values.

Reset (`rst_n`=0 at an edge):
- `pending` = 0.
- `last` = 1, so the ALU wins the first tie.
- `rf_wr_en`, `rf_wr_addr`, `rf_wr_data` = 0.
- Combinational outputs (`issue_stall`, `alu_ready`, `lsu_ready`) are still driven while reset is held.
- Reset mid-operation discards all in-flight pending state. Requests presented during reset are not written.

## Timing
- Grant in cycle N puts the port write in N+1. The register file holds the value at the end of N+1 and it is readable in N+2.
- Pending clear takes effect at the end of N+1, so a stall on that register drops in cycle N+2.
- Issue-to-pending latency is 1 edge. A dependent instruction presented in the cycle after issue stalls.
- The scheduler sustains 1 write per cycle. Under contention each source receives at least 1 grant every 2 cycles.

## Structure
- Package `regfile_pkg`:
  - `XLEN` and `REG_AW` defaults.
  - `NUM_REGS = 2**REG_AW`.
  - typedef `reg_addr_t`.
  - enum `wb_src_e {WB_ALU, WB_LSU}`.
- Sub-module `wb_rr_arbiter`: 2-request round-robin arbiter that owns `last`, with inputs `req[1:0]` and outputs `gnt[1:0]`.
- Top level holds the scoreboard and the write-port registers.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with both sources valid. Required: `rf_wr_en`=0, `issue_stall`=0 for any rs, and the first tie after release grants the ALU.
- Contention: ALU and LSU both valid continuously for 4 cycles, ALU rd=3 data=0xA, LSU rd=4 data=0xB, both requests held. Required: grants alternate ALU, LSU, ALU, LSU, and the port writes (3,0xA), (4,0xB), … one cycle after each grant.
- x0 suppression: ALU valid with rd=0, data=0xFFFF_FFFF. Required: `alu_ready`=1 and `rf_wr_en` stays 0 the next cycle.
- RAW stall: issue rd=5 accepted in cycle 0; cycle 1 issues rs1=5 and LSU writes rd=5, granted in cycle 1. Required: stall=1 in cycles 1–2, `rf_wr_en`=1 with addr 5 in cycle 2, stall=0 in cycle 3.
- Set/clear collision: `rf_wr_en` with addr 7 in the same cycle as an accepted issue with rd=7. Required: `pending[7]` remains 1 and a subsequent rs1=7 stalls.
- Mid-operation reset: with `pending[9]` set and a granted write in flight, assert reset. Required: `pending` = 0 and `rf_wr_en`=0 in the following cycle.
